sram_wb_port: RTL and testbench

//  Wishbone-classic slave that drives port 0 (RW) of a 1rw1r OpenRAM SRAM macro; the bus-side initiator for the macro.

---
 rtl/sram_wb_pkg.sv | 28 ++
 rtl/sram_wb_clear_seq.sv | 30 +++
 rtl/sram_wb_port.sv | 148 ++++++++++++++
 tb/tb_sram_wb_port.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_wb_pkg.sv
// Shared definitions for the Wishbone-to-SRAM port 0 controller.
package sram_wb_pkg;

    // State encodings, kept as explicit values so waveform dumps read the same across tools.
    localparam logic [2:0] ST_INIT_ENC    = 3'd0;
    localparam logic [2:0] ST_IDLE_ENC    = 3'd1;
    localparam logic [2:0] ST_RD_WAIT_ENC = 3'd2;
    localparam logic [2:0] ST_RD_CAP_ENC  = 3'd3;
    localparam logic [2:0] ST_WR_ENC      = 3'd4;
    localparam logic [2:0] ST_ACK_ENC     = 3'd5;

    typedef enum logic [2:0] {
        ST_INIT    = ST_INIT_ENC,
        ST_IDLE    = ST_IDLE_ENC,
        ST_RD_WAIT = ST_RD_WAIT_ENC,
        ST_RD_CAP  = ST_RD_CAP_ENC,
        ST_WR      = ST_WR_ENC,
        ST_ACK     = ST_ACK_ENC
    } state_t;

    // All byte lanes enabled, used by the clear engine.
    localparam logic [3:0] WMASK_ALL = 4'hF;

    // Bus latencies in cycles from the accepting edge to the edge that raises ack.
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

endpackage

// File: rtl/sram_wb_clear_seq.sv
// Word counter for the post-reset zero-fill of the SRAM array.
// The count is the address to issue this cycle; done rises on the edge that issues the last word.
module sram_wb_clear_seq #(
    parameter int ADDR_WIDTH     = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  last,
    output logic                  done
);

    assign last = &count;

    // Count issued words; without a clear the sequence is considered finished out of reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
            done  <= ~CLEAR_ON_RESET;
        end else if (step && !done) begin
            count <= count + 1'b1;
            if (last) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_wb_port.sv
// Wishbone-classic slave driving port 0 (RW) of a 1rw1r OpenRAM macro.
// Every macro-side and bus-side output is a flop; the macro reads on the negedge after
// its capture edge, so read data is taken one full cycle after the capture edge.
//
// state      | meaning
// -----------+----------------------------------------------------------------
// ST_INIT    | zero-filling the array, one word per cycle, bus not serviced
// ST_IDLE    | waiting for cyc&stb; on accept drives the macro request
// ST_RD_WAIT | macro captures the read request this edge
// ST_RD_CAP  | macro data valid; register it and raise ack
// ST_WR      | macro captures the write this edge; raise ack
// ST_ACK     | drop ack, ignore the still-high strobe for one cycle
module sram_wb_port
    import sram_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_WMASKS     = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [NUM_WMASKS-1:0] wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [DATA_WIDTH-1:0] wbs_dat_i,
    output logic [DATA_WIDTH-1:0] wbs_dat_o,
    output logic                  wbs_ack_o,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  init_done_o
);

    state_t                state;
    logic                  req;
    logic                  clr_step;
    logic [ADDR_WIDTH-1:0] clr_count;
    logic                  clr_last;
    logic                  clr_done;

    // Byte-offset bits and bits above the array alias away.
    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[31:ADDR_WIDTH+2], wbs_adr_i[1:0]};

    assign req      = wbs_cyc_i & wbs_stb_i;
    assign clr_step = (state == ST_INIT);

    sram_wb_clear_seq #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk    (clk),
        .resetn (resetn),
        .step   (clr_step),
        .count  (clr_count),
        .last   (clr_last),
        .done   (clr_done)
    );

    assign init_done_o = clr_done;

    // Single FSM owning the macro request registers and the bus response registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    // The last word is issued on the same edge as the move to idle;
                    // idle releases csb0 on its first edge, after the macro has captured it.
                    sram_csb0   <= 1'b0;
                    sram_web0   <= 1'b0;
                    sram_wmask0 <= NUM_WMASKS'(WMASK_ALL);
                    sram_din0   <= '0;
                    sram_addr0  <= clr_count;
                    if (clr_last) begin
                        state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    wbs_ack_o <= 1'b0;
                    if (req) begin
                        sram_addr0  <= wbs_adr_i[ADDR_WIDTH+1:2];
                        sram_din0   <= wbs_dat_i;
                        sram_csb0   <= 1'b0;
                        sram_web0   <= ~wbs_we_i;
                        sram_wmask0 <= wbs_we_i ? wbs_sel_i : '0;
                        state       <= wbs_we_i ? ST_WR : ST_RD_WAIT;
                    end else begin
                        sram_csb0   <= 1'b1;
                        sram_web0   <= 1'b1;
                        sram_wmask0 <= '0;
                    end
                end

                ST_RD_WAIT: begin
                    sram_csb0 <= 1'b1;
                    sram_web0 <= 1'b1;
                    state     <= ST_RD_CAP;
                end

                ST_RD_CAP: begin
                    // An abandoned cycle still walks through ACK, just without the pulse.
                    wbs_dat_o <= sram_dout0;
                    wbs_ack_o <= req;
                    state     <= ST_ACK;
                end

                ST_WR: begin
                    // The write commits regardless of whether the master is still there.
                    sram_csb0   <= 1'b1;
                    sram_web0   <= 1'b1;
                    sram_wmask0 <= '0;
                    wbs_ack_o   <= req;
                    state       <= ST_ACK;
                end

                ST_ACK: begin
                    wbs_ack_o <= 1'b0;
                    state     <= ST_IDLE;
                end

                default: begin
                    sram_csb0   <= 1'b1;
                    sram_web0   <= 1'b1;
                    sram_wmask0 <= '0;
                    wbs_ack_o   <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_wb_port.sv
// Bench for sram_wb_port paired with a behavioural 32x256 port-0 macro model.
module tb_sram_wb_port;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic        wbs_ack_o;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0, sram_dout0;
    logic        init_done_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    logic        preload_en = 1'b0;
    logic [31:0] preload_val = 32'h0;

    always #5 clk = ~clk;

    sram_wb_port #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (32),
        .NUM_WMASKS     (4),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_dat_o   (wbs_dat_o),
        .wbs_ack_o   (wbs_ack_o),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0),
        .init_done_o (init_done_o)
    );

    // Macro model: inputs registered on posedge, array access on the following negedge.
    logic        m_csb, m_web;
    logic [3:0]  m_mask;
    logic [7:0]  m_addr;
    logic [31:0] m_din;

    always @(posedge clk) begin
        m_csb  <= sram_csb0;
        m_web  <= sram_web0;
        m_mask <= sram_wmask0;
        m_addr <= sram_addr0;
        m_din  <= sram_din0;
    end

    always @(negedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = preload_val;
        end else if (m_csb === 1'b0) begin
            if (m_web === 1'b0) begin
                for (int b = 0; b < 4; b++)
                    if (m_mask[b]) mem[m_addr][8*b +: 8] = m_din[8*b +: 8];
            end else begin
                sram_dout0 = mem[m_addr];
            end
        end
    end

    function automatic logic [31:0] readWord(input int idx);
        return mem[idx];
    endfunction

    function automatic int word_of(input logic [31:0] adr);
        return int'((adr / 4) % DEPTH);
    endfunction

    task automatic ref_write(input int idx, input logic [3:0] sel, input logic [31:0] dat);
        for (int b = 0; b < 4; b++)
            if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
    endtask

    task automatic ref_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    endtask

    task automatic preload(input logic [31:0] val);
        preload_val = val;
        preload_en  = 1'b1;
        @(negedge clk);
        @(posedge clk);
        preload_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic hold_reset(input int n);
        resetn    = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Releases reset at a negedge and watches the clear engine until init_done_o.
    task automatic release_and_clear(output int cyc_cnt, output int wr_cnt, output int addr_bad);
        cyc_cnt  = 0;
        wr_cnt   = 0;
        addr_bad = 0;
        resetn   = 1'b1;
        while (init_done_o !== 1'b1 && cyc_cnt < 1000) begin
            @(negedge clk);
            cyc_cnt++;
            if (sram_csb0 === 1'b0 && sram_web0 === 1'b0 && sram_wmask0 === 4'hF && sram_din0 === 32'h0) begin
                if (sram_addr0 !== wr_cnt[7:0]) addr_bad++;
                wr_cnt++;
            end
        end
        repeat (2) @(negedge clk);
        ref_clear();
    endtask

    // One complete bus transfer from a negedge with the slave idle; returns at a negedge.
    task automatic wb_xfer(input bit we_v, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, output logic [31:0] rdat, output int lat,
                           output bit ack_after, output bit rd_mask_bad);
        int  n;
        bit  got;
        n = 0; got = 0; rd_mask_bad = 0; rdat = 32'hx;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we_v;
        wbs_adr_i = adr;  wbs_sel_i = sel;  wbs_dat_i = dat;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            if (!we_v && sram_wmask0 !== 4'h0) rd_mask_bad = 1;
            if (wbs_ack_o === 1'b1) begin
                got  = 1;
                rdat = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        lat = got ? n - 1 : -1;
        @(negedge clk);
        ack_after = wbs_ack_o;
    endtask

    task automatic test_reset();
        int cyc_cnt, wr_cnt, addr_bad, nz;
        preload(32'hA5A5A5A5);
        hold_reset(3);
        checks++; if (sram_csb0 !== 1'b1) begin failures++; $display("FAIL reset_csb0 got=%b exp=1", sram_csb0); end
        checks++; if (sram_web0 !== 1'b1) begin failures++; $display("FAIL reset_web0 got=%b exp=1", sram_web0); end
        checks++; if ({sram_wmask0, sram_addr0, sram_din0} !== 44'h0) begin failures++;
            $display("FAIL reset_drive got mask=%h addr=%h din=%h exp=0", sram_wmask0, sram_addr0, sram_din0); end
        checks++; if ({wbs_ack_o, init_done_o} !== 2'b00 || wbs_dat_o !== 32'h0) begin failures++;
            $display("FAIL reset_bus got ack=%b done=%b dat=%h exp=0", wbs_ack_o, init_done_o, wbs_dat_o); end
        release_and_clear(cyc_cnt, wr_cnt, addr_bad);
        checks++; if (cyc_cnt != 256) begin failures++; $display("FAIL init_latency got=%0d exp=256", cyc_cnt); end
        checks++; if (wr_cnt != 256 || addr_bad != 0) begin failures++;
            $display("FAIL init_writes got=%0d addr_bad=%0d exp=256/0", wr_cnt, addr_bad); end
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (readWord(i) !== 32'h0) nz++;
        checks++; if (nz != 0) begin failures++; $display("FAIL init_zero_fill got nonzero=%0d exp=0", nz); end
    endtask

    task automatic test_basic_rw();
        logic [31:0] rd; int lat; bit aa, mb;
        wb_xfer(1'b1, 32'h40, 4'hF, 32'hDEADBEEF, rd, lat, aa, mb);
        ref_write(word_of(32'h40), 4'hF, 32'hDEADBEEF);
        checks++; if (lat != 1 || aa !== 1'b0) begin failures++; $display("FAIL wr_latency got=%0d ack_after=%b exp=1/0", lat, aa); end
        checks++; if (readWord(16) !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_commit got=%h exp=deadbeef", readWord(16)); end
        wb_xfer(1'b0, 32'h40, 4'hF, 32'h0, rd, lat, aa, mb);
        checks++; if (lat != 2 || aa !== 1'b0) begin failures++; $display("FAIL rd_latency got=%0d ack_after=%b exp=2/0", lat, aa); end
        checks++; if (rd !== ref_mem[16]) begin failures++; $display("FAIL rd_data got=%h exp=%h", rd, ref_mem[16]); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; int lat; bit aa, mb;
        wb_xfer(1'b1, 32'h40, 4'hF, 32'hFFFFFFFF, rd, lat, aa, mb);
        ref_write(16, 4'hF, 32'hFFFFFFFF);
        wb_xfer(1'b1, 32'h40, 4'b0101, 32'h11223344, rd, lat, aa, mb);
        ref_write(16, 4'b0101, 32'h11223344);
        wb_xfer(1'b0, 32'h40, 4'hF, 32'h0, rd, lat, aa, mb);
        checks++; if (rd !== 32'hFF22FF44 || rd !== ref_mem[16]) begin failures++; $display("FAIL sel_0101 got=%h exp=ff22ff44", rd); end
        checks++; if (mb !== 1'b0) begin failures++; $display("FAIL rd_wmask got=nonzero exp=0"); end
        wb_xfer(1'b1, 32'h40, 4'h0, 32'h00000000, rd, lat, aa, mb);
        checks++; if (lat != 1) begin failures++; $display("FAIL sel0_ack got lat=%0d exp=1", lat); end
        checks++; if (readWord(16) !== ref_mem[16]) begin failures++; $display("FAIL sel0_nochange got=%h exp=%h", readWord(16), ref_mem[16]); end
        // Upper address bits alias onto the same word.
        wb_xfer(1'b1, 32'hABCD_03FC, 4'hF, 32'hC0FFEE01, rd, lat, aa, mb);
        ref_write(255, 4'hF, 32'hC0FFEE01);
        wb_xfer(1'b0, 32'h0000_03FF, 4'hF, 32'h0, rd, lat, aa, mb);
        checks++; if (rd !== ref_mem[255]) begin failures++; $display("FAIL alias got=%h exp=%h", rd, ref_mem[255]); end
    endtask

    task automatic test_init_hold();
        int t; bit got, early, done_at; logic [31:0] rd;
        preload(32'h5A5A5A5A);
        hold_reset(2);
        resetn = 1'b1;
        t = 0; got = 0; early = 0; done_at = 0; rd = 32'hx;
        repeat (10) begin @(negedge clk); t++; end
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = 32'h08; wbs_sel_i = 4'hF; wbs_dat_i = 32'h0;
        while (!got && t < 400) begin
            @(negedge clk);
            t++;
            if (wbs_ack_o === 1'b1) begin
                got = 1; rd = wbs_dat_o; done_at = init_done_o;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        ref_clear();
        // Clear ends on edge 256, idle accepts on 257, read ack on 259.
        checks++; if (!got || t != 259 || done_at !== 1'b1) begin failures++;
            $display("FAIL init_hold got ack=%0b t=%0d done=%b exp=1/259/1", got, t, done_at); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL init_hold_data got=%h exp=0", rd); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; int lat; bit aa, mb, seen;
        // Read abandoned in RD_WAIT.
        seen = 0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h40; wbs_sel_i = 4'hF;
        @(negedge clk);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        repeat (3) begin @(negedge clk); if (wbs_ack_o === 1'b1) seen = 1; end
        checks++; if (seen) begin failures++; $display("FAIL rd_abort got ack=1 exp=0"); end
        // Write abandoned in WR still commits.
        seen = 0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_adr_i = 32'h80; wbs_sel_i = 4'hF; wbs_dat_i = 32'h600DF00D;
        @(negedge clk);
        wbs_stb_i = 1'b0;
        repeat (3) begin @(negedge clk); if (wbs_ack_o === 1'b1) seen = 1; end
        wbs_cyc_i = 1'b0;
        ref_write(32, 4'hF, 32'h600DF00D);
        checks++; if (seen || readWord(32) !== ref_mem[32]) begin failures++;
            $display("FAIL wr_abort got ack=%b mem=%h exp=0/%h", seen, readWord(32), ref_mem[32]); end
        wb_xfer(1'b1, 32'h44, 4'hF, 32'h12345678, rd, lat, aa, mb);
        ref_write(17, 4'hF, 32'h12345678);
        wb_xfer(1'b0, 32'h44, 4'hF, 32'h0, rd, lat, aa, mb);
        checks++; if (lat != 2 || rd !== ref_mem[17]) begin failures++;
            $display("FAIL post_abort got lat=%0d dat=%h exp=2/%h", lat, rd, ref_mem[17]); end
    endtask

    task automatic test_random();
        logic [31:0] rd, adr, dat, hi; logic [3:0] sel; int lat, idx, bad_d, bad_l; bit aa, mb, we_v;
        bad_d = 0; bad_l = 0;
        for (int i = 0; i < 60; i++) begin
            idx  = $urandom_range(0, 15);
            hi   = $urandom;
            adr  = (hi & 32'hFFFF_FC03) | (idx * 4);
            we_v = $urandom_range(0, 1);
            sel  = 4'($urandom_range(0, 15));
            dat  = $urandom;
            wb_xfer(we_v, adr, sel, dat, rd, lat, aa, mb);
            if (we_v) begin
                ref_write(word_of(adr), sel, dat);
                if (lat != 1) bad_l++;
            end else begin
                if (lat != 2 || mb) bad_l++;
                if (rd !== ref_mem[word_of(adr)]) bad_d++;
            end
        end
        checks++; if (bad_d != 0) begin failures++; $display("FAIL random_data got bad=%0d exp=0", bad_d); end
        checks++; if (bad_l != 0) begin failures++; $display("FAIL random_timing got bad=%0d exp=0", bad_l); end
    endtask

    task automatic test_back_to_back();
        int t, exp_t, accept_t, budget, idx, bad_t, bad_d; bit we_v, got; logic [31:0] dat, exp_d; logic [3:0] sel;
        t = 0; accept_t = 1; bad_t = 0; bad_d = 0;
        for (int i = 0; i < 10; i++) begin
            we_v  = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            idx   = $urandom_range(0, 7);
            sel   = 4'($urandom_range(1, 15));
            dat   = $urandom;
            exp_d = ref_mem[idx];
            wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we_v;
            wbs_adr_i = idx * 4; wbs_sel_i = sel; wbs_dat_i = dat;
            exp_t = accept_t + (we_v ? 1 : 2);
            got = 0; budget = 0;
            while (!got && budget < 20) begin
                @(negedge clk); t++; budget++;
                if (wbs_ack_o === 1'b1) got = 1;
            end
            if (!got || t != exp_t) bad_t++;
            if (!we_v && wbs_dat_o !== exp_d) bad_d++;
            if (we_v) ref_write(idx, sel, dat);
            accept_t = exp_t + 2;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bad_t != 0) begin failures++; $display("FAIL b2b_spacing got bad=%0d exp=0", bad_t); end
        checks++; if (bad_d != 0) begin failures++; $display("FAIL b2b_data got bad=%0d exp=0", bad_d); end
    endtask

    task automatic test_reset_mid_op();
        int cyc_cnt, wr_cnt, addr_bad, nz; logic [31:0] rd; int lat; bit aa, mb;
        preload(32'hA5A5A5A5);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h20; wbs_sel_i = 4'hF; wbs_dat_i = 32'h87654321;
        @(negedge clk);
        resetn = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        checks++; if (sram_csb0 !== 1'b1 || wbs_ack_o !== 1'b0) begin failures++;
            $display("FAIL mid_reset got csb0=%b ack=%b exp=1/0", sram_csb0, wbs_ack_o); end
        release_and_clear(cyc_cnt, wr_cnt, addr_bad);
        checks++; if (cyc_cnt != 256 || wr_cnt != 256 || addr_bad != 0) begin failures++;
            $display("FAIL rerun_init got cyc=%0d wr=%0d addr_bad=%0d exp=256/256/0", cyc_cnt, wr_cnt, addr_bad); end
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (readWord(i) !== 32'h0) nz++;
        checks++; if (nz != 0) begin failures++; $display("FAIL rerun_zero got nonzero=%0d exp=0", nz); end
        wb_xfer(1'b1, 32'h24, 4'b1100, 32'hAABBCCDD, rd, lat, aa, mb);
        ref_write(9, 4'b1100, 32'hAABBCCDD);
        wb_xfer(1'b0, 32'h24, 4'hF, 32'h0, rd, lat, aa, mb);
        checks++; if (rd !== ref_mem[9]) begin failures++; $display("FAIL post_reset_rw got=%h exp=%h", rd, ref_mem[9]); end
    endtask

    initial begin
        resetn    = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
        sram_dout0 = 32'h0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        @(negedge clk);
        test_reset();
        test_basic_rw();
        test_byte_lanes();
        test_abort();
        test_random();
        test_back_to_back();
        test_init_hold();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
